// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD conversion blocks.
// Also provides the minimum digit count needed to represent a binary word of a given width.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;

    // Decimal digits needed to hold 2^bin_w - 1.
    function automatic int unsigned bcd_min_digits(input int unsigned bin_w);
        longint unsigned maxv;
        int unsigned     d;
        maxv = (64'd1 << bin_w) - 64'd1;
        d    = 1;
        while (maxv > 64'd9) begin
            maxv = maxv / 64'd10;
            d    = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: adds 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // 4-bit add, no carry out: input never exceeds 9, so the result is at most 12.
    assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary to packed BCD converter, one bit per clock,
// with valid/ready handshakes on input and output.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          busy
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W must be in 1..32");
    end
    if (DIGITS < bcd_min_digits(BIN_W)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .adjusted (bcd_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // Binary MSB enters digit 0 bit 0.
    assign shifted = {bcd_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = shifted;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, hand-written corner sequences,
// randomized and exhaustive stimulus against a decimal reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [7:0]  in_bin;
    logic        in_ready, out_valid, busy;
    logic [11:0] out_bcd;

    logic        in_valid16, out_ready16;
    logic [15:0] in_bin16;
    logic        in_ready16, out_valid16, busy16;
    logic [19:0] out_bcd16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_bin    (in_bin16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_bcd   (out_bcd16),
        .busy      (busy16)
    );

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] exp;
        int          hold;
    } vec_t;

    // Reference: decimal digits by plain division.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
        logic [31:0]  r;
        int unsigned  p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r = r | (32'((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One transaction on the 8-bit DUT; out_ready held low for 'hold' cycles in DONE.
    task automatic run_txn(input logic [7:0] v, input logic [11:0] exp, input int hold,
                           input string tag);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_bin    = v;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'd8);
        check({tag, " result"}, 32'(out_bcd), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold data"}, 32'(out_bcd), 32'(exp));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " ready back"}, 32'(in_ready), 32'd1);
        check({tag, " retain"}, 32'(out_bcd), 32'(exp));
    endtask

    task automatic run16(input logic [15:0] v, input string tag);
        int k;
        @(negedge clk);
        in_valid16  = 1'b1;
        in_bin16    = v;
        out_ready16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        check({tag, " busy16"}, 32'(busy16), 32'd1);
        k = 0;
        while (!out_valid16 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency16"}, 32'(k), 32'd16);
        check({tag, " result16"}, 32'(out_bcd16), ref_bcd(32'(v), 5));
        @(negedge clk);
        check({tag, " ready16"}, 32'(in_ready16), 32'd1);
    endtask

    initial begin
        vec_t vecs[8];
        int   k;
        logic [7:0] r;

        vecs[0] = '{8'd0,   12'h000, 0};
        vecs[1] = '{8'd255, 12'h255, 0};
        vecs[2] = '{8'd1,   12'h001, 2};
        vecs[3] = '{8'd9,   12'h009, 0};
        vecs[4] = '{8'd10,  12'h010, 1};
        vecs[5] = '{8'd100, 12'h100, 0};
        vecs[6] = '{8'd128, 12'h128, 3};
        vecs[7] = '{8'd199, 12'h199, 0};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bin      = '0;
        out_ready   = 1'b0;
        in_valid16  = 1'b0;
        in_bin16    = '0;
        out_ready16 = 1'b0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_bcd", 32'(out_bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_txn(vecs[i].bin, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));
        end

        // 99 held in DONE while in_valid pulses with 7 are ignored.
        @(negedge clk);
        in_valid  = 1'b1;
        in_bin    = 8'd99;
        out_ready = 1'b0;
        @(negedge clk);
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("hold99 result", 32'(out_bcd), 32'h099);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_bin   = 8'd7;
            @(negedge clk);
            check("hold99 valid", 32'(out_valid), 32'd1);
            check("hold99 data", 32'(out_bcd), 32'h099);
            check("hold99 in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold99 release", 32'(out_valid), 32'd0);
        check("hold99 retain", 32'(out_bcd), 32'h099);
        @(negedge clk);
        check("hold99 no accept", 32'(busy), 32'd0);

        // Back-to-back with in_valid held high.
        in_valid  = 1'b1;
        in_bin    = 8'd10;
        out_ready = 1'b1;
        @(negedge clk);
        in_bin = 8'd128;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b first latency", 32'(k), 32'd8);
        check("b2b first", 32'(out_bcd), 32'h010);
        @(negedge clk);
        check("b2b idle gap", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("b2b second accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("b2b second latency", 32'(k), 32'd8);
        check("b2b second", 32'(out_bcd), 32'h128);
        @(negedge clk);

        // Reset during the 4th SHIFT cycle of 200.
        in_valid = 1'b1;
        in_bin   = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_bcd", 32'(out_bcd), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("abort no result", 32'(k), 32'd0);
        run_txn(8'd200, 12'h200, 0, "after abort");

        for (int i = 0; i < 40; i++) begin
            r = 8'($urandom_range(0, 255));
            run_txn(r, 12'(ref_bcd(32'(r), 3)), int'($urandom_range(0, 2)), "rand");
        end

        for (int v = 0; v < 256; v++) begin
            run_txn(8'(v), 12'(ref_bcd(32'(v), 3)), 0, "sweep");
        end

        run16(16'd65535, "full16");
        check("full16 literal", 32'(out_bcd16), 32'h65535);
        run16(16'd0, "zero16");
        for (int i = 0; i < 10; i++) begin
            run16(16'($urandom_range(0, 65535)), "rand16");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
